// File: rtl/hand_range_transmitter.sv
// ---------------------------------------------------------------------------
// hand_range_transmitter
//
// Front-end for one hand channel of the handwash sensor. It fires an
// ultrasonic ranger and measures the echo pulse width in clk cycles. It also
// runs a small automatic gain loop. Results leave as data buses qualified by
// single-cycle accept strobes.
//
// Ports
//   clk            in   1   system clock
//   reset          in   1   asynchronous, active-high reset
//   enable         in   1   start a measurement cycle (looked at in IDLE only)
//   echo           in   1   asynchronous echo pulse from the ranger
//   trigger        out  1   ranger trigger pulse, TRIGGER_CYCLES wide
//   acceptDistance out  1   one-cycle strobe, distance valid
//   distance       out  16  echo width in clk cycles, 16'hFFFF on timeout
//   acceptGain     out  1   one-cycle strobe, gain valid (only when it changed)
//   gain           out  8   current gain
//   busy           out  1   high in every state except IDLE
//
// State     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for enable; the period counter is armed on leaving
// TRIGGER   | trigger high for TRIGGER_CYCLES cycles
// WAIT_ECHO | waiting for a fresh echo rise, timeout counter running
// MEASURE   | counting echo width, timeout counter still running
// REPORT    | distance stable, gain update computed
// GAIN      | acceptDistance high, new gain stable
// HOLDOFF   | acceptGain in first cycle if gain moved; wait for period end
// ---------------------------------------------------------------------------
module hand_range_transmitter #(
    parameter int         TRIGGER_CYCLES = 10,
    parameter int         TIMEOUT_CYCLES = 60000,
    parameter int         PERIOD_CYCLES  = 100000,
    parameter logic [7:0] GAIN_INIT      = 8'h40,
    parameter int         GAIN_STEP      = 4,
    parameter int         LOW_MARK       = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        echo,
    output logic        trigger,
    output logic        acceptDistance,
    output logic [15:0] distance,
    output logic        acceptGain,
    output logic [7:0]  gain,
    output logic        busy
);

    localparam int TW = $clog2(TRIGGER_CYCLES + 1);
    localparam int OW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW = $clog2(PERIOD_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIGGER,
        S_WAIT_ECHO,
        S_MEASURE,
        S_REPORT,
        S_GAIN,
        S_HOLDOFF
    } state_t;

    state_t      r_state;

    logic        r_echo_m;
    logic        r_echo_s;
    logic        r_echo_d;

    logic [TW-1:0] r_trig_cnt;
    logic [OW-1:0] r_timeout;
    logic [PW-1:0] r_period;
    logic [15:0]   r_width;
    logic          r_timed_out;
    logic          r_gain_chg;

    logic        r_trigger;
    logic        r_acc_dist;
    logic [15:0] r_distance;
    logic        r_acc_gain;
    logic [7:0]  r_gain;
    logic        r_busy;

    logic        w_echo_rise;
    logic [8:0]  w_gain_up;
    logic [7:0]  w_gain_inc;
    logic [7:0]  w_gain_dec;
    logic [7:0]  w_gain_next;

    assign w_echo_rise = r_echo_s & ~r_echo_d;

    // Gain steps up on timeout (clamped at 255) and down on a close target
    // (clamped at 1). Both are evaluated in REPORT from the final width.
    always_comb begin
        w_gain_up   = {1'b0, r_gain} + 9'(GAIN_STEP);
        w_gain_inc  = w_gain_up[8] ? 8'hFF : w_gain_up[7:0];
        w_gain_dec  = (r_gain <= 8'(GAIN_STEP)) ? 8'h01 : (r_gain - 8'(GAIN_STEP));
        w_gain_next = r_gain;
        if (r_timed_out) begin
            w_gain_next = w_gain_inc;
        end else if (r_width < 16'(LOW_MARK)) begin
            w_gain_next = w_gain_dec;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_echo_m    <= 1'b0;
            r_echo_s    <= 1'b0;
            r_echo_d    <= 1'b0;
            r_trig_cnt  <= '0;
            r_timeout   <= '0;
            r_period    <= '0;
            r_width     <= '0;
            r_timed_out <= 1'b0;
            r_gain_chg  <= 1'b0;
            r_trigger   <= 1'b0;
            r_acc_dist  <= 1'b0;
            r_distance  <= '0;
            r_acc_gain  <= 1'b0;
            r_gain      <= GAIN_INIT;
            r_busy      <= 1'b0;
        end else begin
            r_echo_m <= echo;
            r_echo_s <= r_echo_m;
            r_echo_d <= r_echo_s;

            // Period down-counter: loaded when leaving IDLE, free-running to 0.
            if (r_period != '0) begin
                r_period <= r_period - 1'b1;
            end

            r_acc_dist <= 1'b0;
            r_acc_gain <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_state    <= S_TRIGGER;
                        r_trigger  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_trig_cnt <= TW'(TRIGGER_CYCLES - 1);
                        // The IDLE cycle itself is period count 0, so the
                        // counter reads PERIOD_CYCLES-2 in the first TRIGGER
                        // cycle and hits 0 exactly one cycle before IDLE.
                        r_period   <= PW'(PERIOD_CYCLES - 2);
                    end
                end

                S_TRIGGER: begin
                    if (r_trig_cnt == '0) begin
                        r_state   <= S_WAIT_ECHO;
                        r_trigger <= 1'b0;
                        r_timeout <= OW'(TIMEOUT_CYCLES - 1);
                    end else begin
                        r_trig_cnt <= r_trig_cnt - 1'b1;
                    end
                end

                S_WAIT_ECHO: begin
                    // Timeout wins over a coincident rise so the terminal
                    // count can never be stepped over.
                    if (r_timeout == '0) begin
                        r_state     <= S_REPORT;
                        r_timed_out <= 1'b1;
                        r_distance  <= 16'hFFFF;
                    end else begin
                        r_timeout <= r_timeout - 1'b1;
                        if (w_echo_rise) begin
                            r_state <= S_MEASURE;
                            r_width <= 16'd1;
                        end
                    end
                end

                S_MEASURE: begin
                    if (r_timeout == '0) begin
                        r_state     <= S_REPORT;
                        r_timed_out <= 1'b1;
                        r_distance  <= 16'hFFFF;
                    end else begin
                        r_timeout <= r_timeout - 1'b1;
                        if (r_echo_s) begin
                            if (r_width != 16'hFFFF) begin
                                r_width <= r_width + 16'd1;
                            end
                        end else begin
                            // echo_s was high last cycle here, so low means a fall.
                            r_state     <= S_REPORT;
                            r_timed_out <= 1'b0;
                            r_distance  <= r_width;
                        end
                    end
                end

                S_REPORT: begin
                    // distance was loaded on entry, so it is already stable
                    // one cycle ahead of its strobe.
                    r_gain     <= w_gain_next;
                    r_gain_chg <= (w_gain_next != r_gain);
                    r_acc_dist <= 1'b1;
                    r_state    <= S_GAIN;
                end

                S_GAIN: begin
                    r_acc_gain <= r_gain_chg;
                    r_state    <= S_HOLDOFF;
                end

                S_HOLDOFF: begin
                    if (r_period == '0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_trigger <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign trigger        = r_trigger;
    assign acceptDistance = r_acc_dist;
    assign distance       = r_distance;
    assign acceptGain     = r_acc_gain;
    assign gain           = r_gain;
    assign busy           = r_busy;

endmodule

// File: tb/tb_hand_range_transmitter.sv
// ---------------------------------------------------------------------------
// tb_hand_range_transmitter
//
// Scoreboarded bench: each measurement pushes its expected distance, and its
// expected gain when the gain should change. A forked monitor pops and checks
// them when the strobes appear.
// ---------------------------------------------------------------------------
module tb_hand_range_transmitter;

    localparam int         TRIG  = 4;
    localparam int         TMO   = 200;
    localparam int         PER   = 400;
    localparam logic [7:0] GINIT = 8'h20;
    localparam int         STEP  = 4;
    localparam int         LOWM  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        echo;
    logic        trigger;
    logic        acceptDistance;
    logic [15:0] distance;
    logic        acceptGain;
    logic [7:0]  gain;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] q_dist[$];
    logic [7:0]  q_gain[$];
    logic [7:0]  m_gain;

    hand_range_transmitter #(
        .TRIGGER_CYCLES (TRIG),
        .TIMEOUT_CYCLES (TMO),
        .PERIOD_CYCLES  (PER),
        .GAIN_INIT      (GINIT),
        .GAIN_STEP      (STEP),
        .LOW_MARK       (LOWM)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .echo           (echo),
        .trigger        (trigger),
        .acceptDistance (acceptDistance),
        .distance       (distance),
        .acceptGain     (acceptGain),
        .gain           (gain),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Reference gain loop; queues the expected strobes for one measurement.
    function automatic void push_expect(input logic [15:0] e_d, input int len);
        int mg;
        int ng;
        mg = int'(m_gain);
        if (e_d == 16'hFFFF)    ng = (mg + STEP > 255) ? 255 : mg + STEP;
        else if (len < LOWM)    ng = (mg - STEP < 1) ? 1 : mg - STEP;
        else                    ng = mg;
        q_dist.push_back(e_d);
        if (ng != mg) q_gain.push_back(8'(ng));
        m_gain = 8'(ng);
    endfunction

    task automatic monitor();
        logic [15:0] prev_dist = '0;
        logic [7:0]  prev_gain = '0;
        logic [15:0] e_d;
        logic [7:0]  e_g;
        bit          last_ad = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (acceptDistance === 1'b1 || acceptGain === 1'b1) begin
                n_tests++;
                if (acceptDistance === 1'b1 && acceptGain === 1'b1) begin
                    n_fail++;
                    $display("FAIL strobe_overlap: both strobes high at %0t", $time);
                end
            end
            if (acceptDistance === 1'b1) begin
                n_tests++;
                if (q_dist.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_distance: strobe with distance=%h, none expected", distance);
                end else begin
                    e_d = q_dist.pop_front();
                    if (distance !== e_d) begin
                        n_fail++;
                        $display("FAIL distance_value: got %h expected %h", distance, e_d);
                    end
                end
                n_tests++;
                if (distance !== prev_dist) begin
                    n_fail++;
                    $display("FAIL distance_stable: got %h, previous cycle %h", distance, prev_dist);
                end
            end
            if (acceptGain === 1'b1) begin
                n_tests++;
                if (q_gain.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_gain: strobe with gain=%h, none expected", gain);
                end else begin
                    e_g = q_gain.pop_front();
                    if (gain !== e_g) begin
                        n_fail++;
                        $display("FAIL gain_value: got %h expected %h", gain, e_g);
                    end
                end
                n_tests++;
                if (gain !== prev_gain || last_ad !== 1'b1) begin
                    n_fail++;
                    $display("FAIL gain_timing: gain %h prev %h, distance strobe previous cycle=%0d (need 1)",
                             gain, prev_gain, last_ad);
                end
            end
            last_ad   = (acceptDistance === 1'b1);
            prev_dist = distance;
            prev_gain = gain;
        end
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            if (q_dist.size() == 0 && q_gain.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL drain: %0d distance / %0d gain strobes still pending after 600 cycles",
                     q_dist.size(), q_gain.size());
            q_dist.delete();
            q_gain.delete();
        end
        n_tests++;
        if (gain !== m_gain) begin
            n_fail++;
            $display("FAIL gain_held: got %h expected %h", gain, m_gain);
        end
    endtask

    // One measurement: wait for the trigger, check its width, drive the echo.
    // len=0 means no echo; hold leaves echo high; an echo already high on
    // entry is left alone.
    task automatic measure(input int delay, input int len, input bit hold, input bit drop_en);
        bit          found = 1'b0;
        bit          pre_high;
        int          hi;
        logic [15:0] e_d;
        pre_high = (echo === 1'b1);
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (trigger === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL trigger_wait: no trigger within 1000 cycles");
            return;
        end
        hi = 1;
        while (trigger === 1'b1 && hi < 100) begin
            @(posedge clk); #1;
            if (trigger === 1'b1) hi++;
        end
        n_tests++;
        if (hi != TRIG) begin
            n_fail++;
            $display("FAIL trigger_width: got %0d cycles expected %0d", hi, TRIG);
        end
        if (drop_en) enable = 1'b0;
        e_d = (pre_high || len == 0 || hold) ? 16'hFFFF : 16'(len);
        push_expect(e_d, len);
        if (!pre_high && len > 0) begin
            repeat (delay) begin @(posedge clk); #1; end
            echo = 1'b1;
            if (!hold) begin
                repeat (len) begin @(posedge clk); #1; end
                echo = 1'b0;
            end
        end
        drain();
    endtask

    task automatic test_reset();
        bit found = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({trigger, acceptDistance, acceptGain, distance, gain, busy} !== {3'b000, 16'h0000, GINIT, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: trig=%b ad=%b ag=%b dist=%h gain=%h busy=%b", trigger,
                     acceptDistance, acceptGain, distance, gain, busy);
        end
        reset  = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (trigger === 1'b1) found = 1'b1;
            if (found && trigger === 1'b0) break;
        end
        echo = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_measuring: got %b expected 1", busy);
        end
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if ({trigger, acceptDistance, acceptGain, distance, gain, busy} !== {3'b000, 16'h0000, GINIT, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_measure: trig=%b ad=%b ag=%b dist=%h gain=%h busy=%b", trigger,
                     acceptDistance, acceptGain, distance, gain, busy);
        end
        echo = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_normal();
        measure(2, 100, 1'b0, 1'b0);
    endtask

    task automatic test_short();
        measure(3, 10, 1'b0, 1'b0);
    endtask

    task automatic test_echo_stuck();
        measure(5, 1, 1'b1, 1'b0);
        measure(0, 0, 1'b0, 1'b0);
        echo = 1'b0;
    endtask

    task automatic test_gain_floor();
        measure(2, 1, 1'b0, 1'b0);
        for (int i = 0; i < 70 && m_gain != 8'h01; i++) measure(3, 10, 1'b0, 1'b0);
        measure(3, 8, 1'b0, 1'b0);
    endtask

    task automatic test_timeout_sat();
        for (int i = 0; i < 80 && m_gain != 8'hFF; i++) measure(0, 0, 1'b0, 1'b0);
        measure(0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_period();
        bit   found = 1'b0;
        bit   got   = 1'b0;
        logic prev_trig;
        int   cnt   = 0;
        int   lows  = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (trigger === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL period_start: no trigger within 1000 cycles");
            return;
        end
        push_expect(16'hFFFF, 0);
        prev_trig = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            cnt++;
            if (busy === 1'b0) lows++;
            if (trigger === 1'b1 && prev_trig === 1'b0) begin
                got = 1'b1;
                break;
            end
            prev_trig = trigger;
        end
        n_tests++;
        if (!got || cnt != PER) begin
            n_fail++;
            $display("FAIL period_spacing: got %0d cycles (found=%0d) expected %0d", cnt, got, PER);
        end
        n_tests++;
        if (lows != 1) begin
            n_fail++;
            $display("FAIL period_busy: busy low %0d cycles expected 1", lows);
        end
        push_expect(16'hFFFF, 0);
        drain();
    endtask

    task automatic test_enable_drop();
        int trig_seen = 0;
        measure(2, 40, 1'b0, 1'b1);
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (trigger === 1'b1) trig_seen++;
        end
        n_tests++;
        if (trig_seen != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_drop: trigger cycles=%0d busy=%b expected 0 and 0", trig_seen, busy);
        end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        echo   = 1'b0;
        m_gain = GINIT;
        fork
            monitor();
        join_none
        test_reset();
        test_normal();
        test_short();
        test_echo_stuck();
        test_gain_floor();
        test_timeout_sat();
        test_period();
        test_enable_drop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
